// File: rtl/param_seq_adder.sv
// param_seq_adder: multi-cycle add/subtract that processes SEG bits per clock.
module param_seq_adder #(
    parameter int WIDTH = 8,
    parameter int SEG   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = (SEG < 1) ? 1 : WIDTH / SEG;
    localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    if (SEG < 1 || ((SEG < 1) ? 1 : WIDTH % SEG) != 0) begin : g_bad_params
        $error("param_seq_adder: WIDTH must be a positive multiple of SEG");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
    logic             c_q, c_d, sub_q, sub_d, sa_q, sa_d, sb_q, sb_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [SEG:0]     seg_s;
    logic             last, accept;
    logic [WIDTH-1:0] b_eff;

    assign last   = idx_q == IW'(NSEG - 1);
    assign accept = start && state_q != RUN;
    assign b_eff  = sub ? ~b : b;
    assign seg_s  = {1'b0, a_q[SEG-1:0]} + {1'b0, b_q[SEG-1:0]} + {{SEG{1'b0}}, c_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = (state_q == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    // Operands shift right one segment per cycle; result segments enter from the top.
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        r_d    = r_q;
        c_d    = c_q;
        sub_d  = sub_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (accept) begin
            idx_d = '0;
            a_d   = a;
            b_d   = b_eff;
            r_d   = '0;
            c_d   = sub ? ~cin : cin;
            sub_d = sub;
            sa_d  = a[WIDTH-1];
            sb_d  = b_eff[WIDTH-1];
        end else if (state_q == RUN) begin
            idx_d = idx_q + IW'(1);
            a_d   = a_q >> SEG;
            b_d   = b_q >> SEG;
            c_d   = seg_s[SEG];
            r_d   = (r_q >> SEG) | (WIDTH'(seg_s[SEG-1:0]) << (WIDTH - SEG));
            if (last) begin
                sum_d  = r_d;
                cout_d = sub_q ^ seg_s[SEG];
                ovf_d  = (sa_q == sb_q) && (r_d[WIDTH-1] != sa_q);
            end
        end
    end

    always_comb begin
        busy = state_q == RUN;
        done = state_q == DONE;
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end
endmodule

// File: tb/tb_param_seq_adder.sv
// tb_param_seq_adder: directed and random checks of param_seq_adder against an arithmetic model.
module tb_param_seq_adder;
    logic       clk = 1'b0;
    logic       rst_n, start, sub, cin;
    logic [7:0] a, b, sum;
    logic       busy, done, cout, ovf;
    logic       s_start, s_sub, s_cin, s_busy, s_done, s_cout, s_ovf;
    logic [1:0] s_a, s_b, s_sum;

    int total = 0;
    int bad   = 0;

    param_seq_adder #(.WIDTH(8), .SEG(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    param_seq_adder #(.WIDTH(2), .SEG(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
        .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic void ref_op(input logic s, input logic [7:0] x, input logic [7:0] y,
                                   input logic ci, output logic [7:0] r, output logic co,
                                   output logic ov);
        int t, sx, sy, ts;
        sx = x[7] ? int'(x) - 256 : int'(x);
        sy = y[7] ? int'(y) - 256 : int'(y);
        if (!s) begin
            t  = int'(x) + int'(y) + int'(ci);
            ts = sx + sy + int'(ci);
            co = t > 255;
        end else begin
            t  = int'(x) - int'(y) - int'(ci);
            ts = sx - sy - int'(ci);
            co = t < 0;
        end
        r  = t[7:0];
        ov = ts > 127 || ts < -128;
    endfunction

    // Timing model: result appears 4 edges after acceptance, held until the next one.
    logic       m_busy, m_done, m_cout, m_ovf, p_cout, p_ovf;
    logic [7:0] m_sum, p_sum;
    int         m_cnt, n_acc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_sum = 0; m_cout = 0; m_ovf = 0; m_cnt = 0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0; m_done = 1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else if (start) begin
            ref_op(sub, a, b, cin, p_sum, p_cout, p_ovf);
            m_cnt = 4; m_busy = 1; m_done = 0; n_acc++;
        end else begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("sum", 32'(sum), 32'(m_sum));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("ovf", 32'(ovf), 32'(m_ovf));
        end
    end

    task automatic drive(input logic s, input logic [7:0] x, input logic [7:0] y, input logic ci);
        start = 1; sub = s; a = x; b = y; cin = ci;
    endtask

    task automatic wait_done(inout int n);
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input logic s, input logic [7:0] x, input logic [7:0] y, input logic ci,
                      output int n);
        @(negedge clk);
        drive(s, x, y, ci);
        @(negedge clk);
        start = 0;
        n = 0;
        wait_done(n);
    endtask

    initial begin
        int n, dcount;
        rst_n = 0; start = 0; sub = 0; a = 0; b = 0; cin = 0;
        s_start = 0; s_sub = 0; s_a = 0; s_b = 0; s_cin = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout_ovf", {cout, ovf}, 0);
        chk("rst_small", {s_busy, s_done, s_sum, s_cout, s_ovf}, 0);
        rst_n = 1;

        op(0, 200, 100, 0, n);
        chk("add1_edge", n, 4);
        chk("add1_res", {sum, cout, ovf}, {8'd44, 1'b1, 1'b0});
        // back-to-back: start held during the DONE cycle
        drive(1, 5, 10, 0);
        @(negedge clk);
        start = 0;
        chk("b2b_busy", 32'(busy), 1);
        n = 0;
        wait_done(n);
        chk("b2b_edge", n, 4);
        chk("sub_res", {sum, cout, ovf}, {8'd251, 1'b1, 1'b0});

        op(0, 100, 50, 1, n);
        chk("add2_edge", n, 4);
        chk("add2_res", {sum, cout, ovf}, {8'd151, 1'b0, 1'b1});

        // start with new operands at edge 2 must be ignored
        @(negedge clk);
        drive(0, 10, 20, 0);
        @(negedge clk);
        start = 0;
        @(negedge clk);
        drive(1, 255, 255, 1);
        @(negedge clk);
        start = 0;
        n = 2;
        wait_done(n);
        chk("ign_edge", n, 4);
        chk("ign_res", {sum, cout, ovf}, {8'd30, 1'b0, 1'b0});

        // reset asserted before edge 2 of an operation
        @(negedge clk);
        drive(0, 1, 2, 0);
        @(negedge clk);
        start = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst_out", {busy, done, sum, cout, ovf}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("midrst_nodone", dcount, 0);

        // WIDTH=2, SEG=1 instance
        @(negedge clk);
        s_start = 1; s_sub = 0; s_a = 3; s_b = 3; s_cin = 1;
        @(negedge clk);
        s_start = 0;
        n = 0;
        while (!s_done && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("small_edge", n, 2);
        chk("small_res", {s_sum, s_cout, s_ovf}, {2'd3, 1'b1, 1'b0});

        // random traffic, inputs also toggling while busy
        n_acc = 0;
        for (int i = 0; i < 6000 && n_acc < 200; i++) begin
            @(negedge clk);
            start = $urandom_range(0, 3) == 0;
            sub = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
        end
        chk("rand_count", 32'(n_acc >= 200), 1);
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/param_seq_adder.md
PARAM_SEQ_ADDER -- requirements
Module: param_seq_adder

Interface
REQ-001 The block SHALL declare parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL declare parameter SEG, default 2, meaning bits added per clock cycle; NSEG = WIDTH/SEG segments.
REQ-003 The block SHALL run on one clock, with an asynchronous, active-low reset.
REQ-004 The block SHALL have these ports, in this order:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation
- sub  input  1  0 = add, 1 = subtract
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) or borrow-in (subtract)
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
- sum  output  WIDTH  result
- cout  output  1  carry-out (add) or borrow-out (subtract)
- ovf  output  1  two's-complement signed overflow

Function
REQ-005 The block SHALL reject WIDTH%SEG != 0 or SEG < 1 with an elaboration-time error.
REQ-006 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-007 In IDLE or DONE, start=1 at a rising edge SHALL:
- latch a, b, sub and cin;
- clear the segment index;
- move the FSM to RUN.
REQ-008 In RUN, start SHALL be ignored, and a, b, sub and cin SHALL not affect the operation in progress.
REQ-009 At each RUN edge, the block SHALL add one SEG-bit segment, starting at bits [SEG-1:0], and register the carry into the next segment.
REQ-010 Add SHALL compute a+b+cin, with cout the unsigned carry out of bit WIDTH-1.
REQ-011 Subtract SHALL compute a-b-cin as a + ~b + ~cin, with cout = 1 exactly when a < b+cin (unsigned).
REQ-012 ovf SHALL be 1 when the operand signs, after inversion of b for subtract, are equal and differ from the result sign.
REQ-013 The edge that processes segment NSEG-1 SHALL:
- load sum, cout and ovf;
- move the FSM to DONE.
REQ-014 Latency SHALL be exactly NSEG+1 edges: start sampled at edge 0, done=1 during the cycle after edge NSEG.
REQ-015 busy SHALL be 1 exactly while the FSM is in RUN, and done SHALL be 1 exactly while the FSM is in DONE.
REQ-016 From DONE, the FSM SHALL move to IDLE at the next edge unless start=1, in which case it SHALL move to RUN (back-to-back operation, no bubble).
REQ-017 sum, cout and ovf SHALL change only at completion and SHALL hold their values until the next completion.
REQ-018 With SEG=WIDTH, the block SHALL complete in one RUN cycle (done after edge 1).

Reset
REQ-019 While rst_n=0, the block SHALL force FSM=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear all internal registers, without waiting for clk.
REQ-020 A reset asserted mid-operation SHALL abort the operation, and no done pulse SHALL follow.
REQ-021 The first start SHALL be accepted at the first rising edge where rst_n=1 and start=1.

Verification
REQ-022 The bench SHALL cover these directed scenarios (WIDTH=8, SEG=2 unless stated):
- add, a=200, b=100, cin=0 -> done at edge 4; sum=44, cout=1, ovf=0.
- add, a=100, b=50, cin=1 -> sum=151, cout=0, ovf=1.
- subtract, a=5, b=10, cin=0 -> sum=251, cout=1, ovf=0.
- start pulsed with new operands at edge 2 of a running operation -> ignored; first result unchanged.
- new start held high during the DONE cycle -> accepted; second done exactly 4 edges later.
- rst_n low at edge 2 of an operation -> all outputs 0 immediately; no done pulse.
- override WIDTH=2, SEG=1, add, a=3, b=3, cin=1 -> done after edge 2; sum=3, cout=1, ovf=0.
REQ-023 The bench SHALL also run at least 200 random operations against a behavioural model, covering both add and subtract.
